// File: rtl/dual_ram_block_reader.sv
// Read-side sequencer for the dual-port sample RAM: streams one block out as sample
// pairs through a 2-entry skid FIFO with full ready/valid backpressure.
module dual_ram_block_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [15:0]       iBaseAddress,
  input  logic [15:0]       iBlockLength,
  output logic [15:0]       oReadAddress1,
  output logic [15:0]       oReadAddress2,
  input  logic [DATA_W-1:0] iRamData1,
  input  logic [DATA_W-1:0] iRamData2,
  output logic [DATA_W-1:0] oSample1,
  output logic [DATA_W-1:0] oSample2,
  output logic              oValid,
  output logic              oValid2,
  output logic              oLast,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oDone
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_e;

  localparam logic [1:0]        FIFO_FULL = 2'(FIFO_DEPTH);
  localparam logic [2:0]        ISSUE_LIM = 3'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_TWO  = ADDR_W'(2);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] nextAddr_q, addr1_q, addr2_q;
  logic [15:0]       issueIdx_q, pairs_q;
  logic              lenOdd_q;

  // addrPend: address register holds a pair not yet pushed; busPend: the RAM outputs
  // currently carry such a pair; busIsAddr: bus pair and address pair are the same one.
  logic addrPend_q, addrLast_q, busPend_q, busLast_q, busIsAddr_q;

  logic [DATA_W-1:0] s1Mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] s2Mem_q [FIFO_DEPTH];
  logic              v2Mem_q [FIFO_DEPTH];
  logic              lastMem_q [FIFO_DEPTH];
  logic              wrPtr_q, rdPtr_q;
  logic [1:0]        count_q;

  logic        pop, push, issue, lastIssue, headLast, busPairConsumed;
  logic [2:0]  occProj;
  logic [15:0] pairsStart;
  logic        unusedBaseBits;

  assign unusedBaseBits = ^iBaseAddress[15:ADDR_W];

  assign pairsStart = {1'b0, iBlockLength[15:1]} + {15'd0, iBlockLength[0]};
  assign pop        = (count_q != 2'd0) && iReady;
  assign push       = busPend_q && ((count_q != FIFO_FULL) || pop);
  assign occProj    = {1'b0, count_q} + {2'b00, busPend_q} - {2'b00, pop};
  assign lastIssue  = (issueIdx_q == pairs_q - 16'd1);
  assign issue      = (state_q == READ) && (occProj < ISSUE_LIM);
  assign headLast   = lastMem_q[rdPtr_q];

  // The pair in the address register is consumed only when it is also the one on the bus.
  assign busPairConsumed = busIsAddr_q && push;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = (iBlockLength == 16'd0) ? FINISH : READ;
        end
      end
      READ: begin
        if (issue && lastIssue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && headLast) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      nextAddr_q  <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      issueIdx_q  <= '0;
      pairs_q     <= '0;
      lenOdd_q    <= 1'b0;
      addrPend_q  <= 1'b0;
      addrLast_q  <= 1'b0;
      busPend_q   <= 1'b0;
      busLast_q   <= 1'b0;
      busIsAddr_q <= 1'b0;
      wrPtr_q     <= 1'b0;
      rdPtr_q     <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        s1Mem_q[i]   <= '0;
        s2Mem_q[i]   <= '0;
        v2Mem_q[i]   <= 1'b0;
        lastMem_q[i] <= 1'b0;
      end
    end else begin
      if ((state_q == IDLE) && iStart) begin
        nextAddr_q <= iBaseAddress[ADDR_W-1:0];
        issueIdx_q <= '0;
        pairs_q    <= pairsStart;
        lenOdd_q   <= iBlockLength[0];
      end

      // A held address re-reads the same words, so a stalled pair stays on the bus.
      if (issue) begin
        addr1_q     <= nextAddr_q;
        addr2_q     <= nextAddr_q + ADDR_ONE;
        nextAddr_q  <= nextAddr_q + ADDR_TWO;
        issueIdx_q  <= issueIdx_q + 16'd1;
        addrPend_q  <= 1'b1;
        addrLast_q  <= lastIssue;
        busIsAddr_q <= 1'b0;
      end else begin
        addrPend_q  <= addrPend_q && !busPairConsumed;
        busIsAddr_q <= 1'b1;
      end

      busPend_q <= addrPend_q && !busPairConsumed;
      busLast_q <= addrLast_q;

      if (push) begin
        s1Mem_q[wrPtr_q]   <= iRamData1;
        s2Mem_q[wrPtr_q]   <= iRamData2;
        v2Mem_q[wrPtr_q]   <= !(busLast_q && lenOdd_q);
        lastMem_q[wrPtr_q] <= busLast_q;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign oReadAddress1 = {{(16-ADDR_W){1'b0}}, addr1_q};
  assign oReadAddress2 = {{(16-ADDR_W){1'b0}}, addr2_q};
  assign oSample1      = s1Mem_q[rdPtr_q];
  assign oSample2      = s2Mem_q[rdPtr_q];
  assign oValid2       = v2Mem_q[rdPtr_q];
  assign oLast         = headLast;
  assign oValid        = (count_q != 2'd0);
  assign oBusy         = (state_q == READ) || (state_q == DRAIN);
  assign oDone         = (state_q == FINISH);

endmodule

// File: tb/tb_dual_ram_block_reader.sv
// Directed bench for dual_ram_block_reader: a registered two-port RAM model holding
// RAM[i] = i + 100, a table of block reads, and a hand-written mid-block reset sequence.
module tb_dual_ram_block_reader;

  logic        iClock = 1'b0;
  logic        iReset, iStart, iReady;
  logic [15:0] iBaseAddress, iBlockLength;
  logic [15:0] oReadAddress1, oReadAddress2;
  logic [15:0] iRamData1, iRamData2;
  logic [15:0] oSample1, oSample2;
  logic        oValid, oValid2, oLast, oBusy, oDone;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [7:0]  readyPat;
    int          patLen;
    int          expPairs;
    logic [15:0] expAddr1;
    logic [15:0] expAddr2;
    logic [15:0] expFirst1;
    logic [15:0] expFirst2;
    logic [15:0] expLast1;
    logic        expLastV2;
    int          expLastAccept;
    int          pulseCycle;
  } vec_t;

  vec_t vecs [7];
  logic [15:0] ram [8192];

  dual_ram_block_reader dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iStart        (iStart),
    .iBaseAddress  (iBaseAddress),
    .iBlockLength  (iBlockLength),
    .oReadAddress1 (oReadAddress1),
    .oReadAddress2 (oReadAddress2),
    .iRamData1     (iRamData1),
    .iRamData2     (iRamData2),
    .oSample1      (oSample1),
    .oSample2      (oSample2),
    .oValid        (oValid),
    .oValid2       (oValid2),
    .oLast         (oLast),
    .iReady        (iReady),
    .oBusy         (oBusy),
    .oDone         (oDone)
  );

  always #5 iClock = ~iClock;

  // Registered read ports: data is valid the cycle after the address is presented.
  always @(posedge iClock) begin
    iRamData1 <= ram[oReadAddress1[12:0]];
    iRamData2 <= ram[oReadAddress2[12:0]];
  end

  function automatic logic [15:0] ramWord(input int addr);
    return 16'((addr % 8192) + 100);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] base, input logic [15:0] len, input logic start);
    iBaseAddress = base;
    iBlockLength = len;
    iStart       = start;
  endtask

  // Cycle 0 is the cycle right after the edge that samples iStart.
  task automatic runBlock(input int idx, input vec_t v);
    int k = 0;
    int firstValid = -1;
    int lastAccept = -1;
    int doneCycle = -1;
    int doneCount = 0;
    int extra = 0;
    int addr;
    logic expV2;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge iClock);
    applyStimulus(v.base, v.len, 1'b1);
    iReady = v.readyPat[0];
    @(negedge iClock);
    for (int cycle = 0; cycle < 400; cycle++) begin
      iReady = v.readyPat[cycle % v.patLen];
      if (cycle == v.pulseCycle) applyStimulus(16'd500, 16'd2, 1'b1);
      else iStart = 1'b0;
      if (cycle == 1 && v.expPairs > 0) begin
        checkOutput({tag, ".addr1"}, oReadAddress1, v.expAddr1);
        checkOutput({tag, ".addr2"}, oReadAddress2, v.expAddr2);
      end
      if (oDone) begin
        doneCount++;
        if (doneCount == 1) doneCycle = cycle;
        checkOutput({tag, ".busyAtDone"}, oBusy, 0);
      end else if (doneCount == 0) begin
        checkOutput({tag, ".busy"}, oBusy, (v.expPairs > 0));
      end
      if (oValid) begin
        if (k < v.expPairs) begin
          if (firstValid < 0) firstValid = cycle;
          addr = int'(v.base) + 2 * k;
          expV2 = !((k == v.expPairs - 1) && v.len[0]);
          checkOutput($sformatf("%s.pair%0d.s1", tag, k), oSample1, ramWord(addr));
          if (expV2) checkOutput($sformatf("%s.pair%0d.s2", tag, k), oSample2, ramWord(addr + 1));
          checkOutput($sformatf("%s.pair%0d.valid2", tag, k), oValid2, expV2);
          checkOutput($sformatf("%s.pair%0d.last", tag, k), oLast, (k == v.expPairs - 1));
          if (iReady) begin
            if (k == 0) begin
              checkOutput({tag, ".firstS1"}, oSample1, v.expFirst1);
              if (v.expPairs > 1 || !v.len[0]) checkOutput({tag, ".firstS2"}, oSample2, v.expFirst2);
            end
            if (k == v.expPairs - 1) begin
              checkOutput({tag, ".lastS1"}, oSample1, v.expLast1);
              checkOutput({tag, ".lastV2"}, oValid2, v.expLastV2);
            end
            lastAccept = cycle;
            k++;
          end
        end else begin
          extra++;
        end
      end
      if (doneCount > 0 && cycle >= doneCycle + 6) break;
      @(negedge iClock);
    end
    iStart = 1'b0;
    checkOutput({tag, ".pairCount"}, k, v.expPairs);
    checkOutput({tag, ".doneCount"}, doneCount, 1);
    checkOutput({tag, ".extraValid"}, extra, 0);
    if (v.expPairs > 0) begin
      checkOutput({tag, ".firstValidCycle"}, firstValid, 3);
      checkOutput({tag, ".doneAfterLast"}, doneCycle, lastAccept + 1);
    end
    if (v.expLastAccept >= 0) checkOutput({tag, ".lastAcceptCycle"}, lastAccept, v.expLastAccept);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t rv;
    int acc;
    for (int i = 0; i < 8192; i++) ram[i] = 16'(i + 100);

    vecs[0] = '{16'd0,    16'd8,  8'h01,        1, 4, 16'd0,    16'd1,    16'd100,  16'd101,  16'd106,  1'b1,  6, -1};
    vecs[1] = '{16'd8190, 16'd5,  8'h01,        1, 3, 16'd8190, 16'd8191, 16'd8290, 16'd8291, 16'd102,  1'b0,  5, -1};
    vecs[2] = '{16'd8191, 16'd2,  8'h01,        1, 1, 16'd8191, 16'd0,    16'd8291, 16'd100,  16'd8291, 1'b1,  3, -1};
    vecs[3] = '{16'd0,    16'd16, 8'b0000_1001, 5, 8, 16'd0,    16'd1,    16'd100,  16'd101,  16'd114,  1'b1, -1, -1};
    vecs[4] = '{16'd0,    16'd0,  8'h01,        1, 0, 16'd0,    16'd0,    16'd0,    16'd0,    16'd0,    1'b0, -1, -1};
    vecs[5] = '{16'd0,    16'd8,  8'h01,        1, 4, 16'd0,    16'd1,    16'd100,  16'd101,  16'd106,  1'b1,  6,  4};
    vecs[6] = '{16'd8000, 16'd7,  8'b0000_0001, 2, 4, 16'd8000, 16'd8001, 16'd8100, 16'd8101, 16'd8106, 1'b0, -1, -1};

    iReset = 1'b1;
    iReady = 1'b0;
    applyStimulus(16'd0, 16'd0, 1'b0);
    repeat (2) @(negedge iClock);
    checkOutput("reset.valid", oValid, 0);
    checkOutput("reset.busy", oBusy, 0);
    checkOutput("reset.done", oDone, 0);
    checkOutput("reset.addr1", oReadAddress1, 0);
    checkOutput("reset.sample1", oSample1, 0);
    checkOutput("reset.last", oLast, 0);
    iReset = 1'b0;

    for (int i = 0; i < 7; i++) runBlock(i, vecs[i]);

    // Abort a long block after 10 accepted pairs, then start a fresh one.
    @(negedge iClock);
    applyStimulus(16'd0, 16'd64, 1'b1);
    iReady = 1'b1;
    @(negedge iClock);
    iStart = 1'b0;
    acc = 0;
    for (int cycle = 0; cycle < 100 && acc < 10; cycle++) begin
      if (oValid && iReady) acc++;
      if (acc < 10) @(negedge iClock);
    end
    checkOutput("abort.accepted", acc, 10);
    @(negedge iClock);
    iReset = 1'b1;
    #1;
    checkOutput("abort.valid", oValid, 0);
    checkOutput("abort.busy", oBusy, 0);
    checkOutput("abort.done", oDone, 0);
    checkOutput("abort.sample1", oSample1, 0);
    checkOutput("abort.addr1", oReadAddress1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge iClock);
      checkOutput("abort.noDone", oDone, 0);
    end
    iReset = 1'b0;
    rv = '{16'd32, 16'd4, 8'h01, 1, 2, 16'd32, 16'd33, 16'd132, 16'd133, 16'd134, 1'b1, 4, -1};
    runBlock(7, rv);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
